// File: rtl/scatter_pkg.sv
// Shared definitions for scatter_stream: FSM state encoding and counter sizing.
package scatter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } scatter_state_t;

    // A counter that must reach n (saturated) needs $clog2(n+1) bits.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/scatter_lane.sv
// One row of scatter_stream: captured row data plus large/small slot registers,
// filled one column per cycle under control of the shared FSM counters.
module scatter_lane
    import scatter_pkg::*;
#(
    parameter int IN_WIDTH          = 16,
    parameter int IN_SIZE           = 4,
    parameter int OUT_LARGE_COLUMNS = 2,
    parameter int OUT_SMALL_COLUMNS = IN_SIZE - OUT_LARGE_COLUMNS,
    parameter int COL_W             = cnt_width(IN_SIZE),
    parameter int LCNT_W            = cnt_width(OUT_LARGE_COLUMNS),
    parameter int SCNT_W            = cnt_width(OUT_SMALL_COLUMNS)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    capture,
    input  logic                                    scan_en,
    input  logic [IN_SIZE*IN_WIDTH-1:0]             row_in,
    input  logic [COL_W-1:0]                        col,
    input  logic                                    route_large,
    input  logic [LCNT_W-1:0]                       cnt_large,
    input  logic [SCNT_W-1:0]                       cnt_small,
    output logic [OUT_LARGE_COLUMNS*IN_WIDTH-1:0]   large_out,
    output logic [OUT_SMALL_COLUMNS*IN_WIDTH-1:0]   small_out
);

    logic [IN_SIZE-1:0][IN_WIDTH-1:0]           row_q, row_d;
    logic [OUT_LARGE_COLUMNS-1:0][IN_WIDTH-1:0] large_q, large_d;
    logic [OUT_SMALL_COLUMNS-1:0][IN_WIDTH-1:0] small_q, small_d;
    logic [IN_WIDTH-1:0]                        elem;

    always_comb begin
        elem = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            if (col == COL_W'(i)) begin
                elem = row_q[i];
            end
        end
    end

    // A saturated counter matches no slot index, so the column is dropped.
    always_comb begin
        row_d   = row_q;
        large_d = large_q;
        small_d = small_q;
        if (capture) begin
            row_d   = row_in;
            large_d = '0;
            small_d = '0;
        end else if (scan_en) begin
            if (route_large) begin
                for (int i = 0; i < OUT_LARGE_COLUMNS; i++) begin
                    if (cnt_large == LCNT_W'(i)) begin
                        large_d[i] = elem;
                    end
                end
            end else begin
                for (int i = 0; i < OUT_SMALL_COLUMNS; i++) begin
                    if (cnt_small == SCNT_W'(i)) begin
                        small_d[i] = elem;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q   <= '0;
            large_q <= '0;
            small_q <= '0;
        end else begin
            row_q   <= row_d;
            large_q <= large_d;
            small_q <= small_d;
        end
    end

    assign large_out = large_q;
    assign small_out = small_q;

endmodule

// File: rtl/scatter_stream.sv
// Streaming large/small column splitter. Optional mask-count check enabled by
// defining SCATTER_ERR_CHECK_EN; otherwise err is tied low.
//   state | meaning
//   IDLE  | ready for a beat (data_in_ready high)
//   SCAN  | routing one column per cycle into the lane slot registers
//   OUT   | slots presented, waiting for data_out_ready
module scatter_stream
    import scatter_pkg::*;
#(
    parameter int IN_WIDTH          = 16,
    parameter int IN_SIZE           = 4,
    parameter int IN_PARALLELISM    = 1,
    parameter int OUT_LARGE_COLUMNS = 2,
    parameter int OUT_SMALL_COLUMNS = IN_SIZE - OUT_LARGE_COLUMNS
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [IN_WIDTH*IN_SIZE*IN_PARALLELISM-1:0]           data_in,
    input  logic [IN_SIZE-1:0]                                   ind_table,
    input  logic                                                 data_in_valid,
    output logic                                                 data_in_ready,
    output logic [IN_WIDTH*OUT_LARGE_COLUMNS*IN_PARALLELISM-1:0] data_out_large,
    output logic [IN_WIDTH*OUT_SMALL_COLUMNS*IN_PARALLELISM-1:0] data_out_small,
    output logic                                                 data_out_valid,
    input  logic                                                 data_out_ready,
    output logic                                                 err
);

    localparam int CW     = cnt_width(IN_SIZE);
    localparam int LW     = cnt_width(OUT_LARGE_COLUMNS);
    localparam int SW     = cnt_width(OUT_SMALL_COLUMNS);
    localparam int ROW_W  = IN_WIDTH * IN_SIZE;
    localparam int LROW_W = IN_WIDTH * OUT_LARGE_COLUMNS;
    localparam int SROW_W = IN_WIDTH * OUT_SMALL_COLUMNS;

    localparam logic [CW-1:0] COL_LAST   = CW'(IN_SIZE - 1);
    localparam logic [LW-1:0] LARGE_FULL = LW'(OUT_LARGE_COLUMNS);
    localparam logic [SW-1:0] SMALL_FULL = SW'(OUT_SMALL_COLUMNS);

    scatter_state_t     state_q, state_d;
    logic [CW-1:0]      col_q, col_d;
    logic [LW-1:0]      cnt_large_q, cnt_large_d;
    logic [SW-1:0]      cnt_small_q, cnt_small_d;
    logic [IN_SIZE-1:0] mask_q, mask_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic               accept, release_beat, route_large, scan_en, scan_last;

    assign accept       = ready_q & data_in_valid & (state_q == IDLE);
    assign release_beat = valid_q & data_out_ready & (state_q == OUT);
    assign scan_en      = (state_q == SCAN);
    assign scan_last    = scan_en & (col_q == COL_LAST);

    always_comb begin
        route_large = 1'b0;
        for (int i = 0; i < IN_SIZE; i++) begin
            if (col_q == CW'(i)) begin
                route_large = mask_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        cnt_large_d = cnt_large_q;
        cnt_small_d = cnt_small_q;
        mask_d      = mask_q;
        ready_d     = ready_q;
        valid_d     = valid_q;
        case (state_q)
            IDLE: begin
                // ready rises one edge after reset release, then drops on accept.
                ready_d = 1'b1;
                if (accept) begin
                    state_d     = SCAN;
                    mask_d      = ind_table;
                    col_d       = '0;
                    cnt_large_d = '0;
                    cnt_small_d = '0;
                    ready_d     = 1'b0;
                end
            end
            SCAN: begin
                if (route_large) begin
                    if (cnt_large_q != LARGE_FULL) cnt_large_d = cnt_large_q + LW'(1);
                end else begin
                    if (cnt_small_q != SMALL_FULL) cnt_small_d = cnt_small_q + SW'(1);
                end
                if (scan_last) begin
                    state_d = OUT;
                    valid_d = 1'b1;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            OUT: begin
                if (release_beat) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            cnt_large_q <= '0;
            cnt_small_q <= '0;
            mask_q      <= '0;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            cnt_large_q <= cnt_large_d;
            cnt_small_q <= cnt_small_d;
            mask_q      <= mask_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
        end
    end

    assign data_in_ready  = ready_q;
    assign data_out_valid = valid_q;

    for (genvar r = 0; r < IN_PARALLELISM; r++) begin : g_lane
        scatter_lane #(
            .IN_WIDTH          (IN_WIDTH),
            .IN_SIZE           (IN_SIZE),
            .OUT_LARGE_COLUMNS (OUT_LARGE_COLUMNS),
            .OUT_SMALL_COLUMNS (OUT_SMALL_COLUMNS),
            .COL_W             (CW),
            .LCNT_W            (LW),
            .SCNT_W            (SW)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .capture     (accept),
            .scan_en     (scan_en),
            .row_in      (data_in[r*ROW_W +: ROW_W]),
            .col         (col_q),
            .route_large (route_large),
            .cnt_large   (cnt_large_q),
            .cnt_small   (cnt_small_q),
            .large_out   (data_out_large[r*LROW_W +: LROW_W]),
            .small_out   (data_out_small[r*SROW_W +: SROW_W])
        );
    end

`ifdef SCATTER_ERR_CHECK_EN
    logic          err_q, err_d;
    logic [CW-1:0] mask_pop;

    always_comb begin
        mask_pop = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            mask_pop = mask_pop + CW'(mask_q[i]);
        end
    end

    always_comb begin
        err_d = err_q;
        if (scan_last) begin
            err_d = (mask_pop != CW'(OUT_LARGE_COLUMNS));
        end else if (release_beat) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_scatter_stream.sv
// Directed bench for scatter_stream: a P=1/L=2 instance driven from a vector
// table plus corner sequences, and a P=2/L=1 instance for multi-row beats.
module tb_scatter_stream;

`ifdef SCATTER_ERR_CHECK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [63:0]  din_a = '0;
    logic [3:0]   ind_a = '0;
    logic         vin_a = 1'b0, rdy_a, vout_a, ordy_a = 1'b0, err_a;
    logic [31:0]  large_a, small_a;

    logic [127:0] din_b = '0;
    logic [3:0]   ind_b = '0;
    logic         vin_b = 1'b0, rdy_b, vout_b, ordy_b = 1'b0, err_b;
    logic [31:0]  large_b;
    logic [95:0]  small_b;

    scatter_stream #(.IN_WIDTH(16), .IN_SIZE(4), .IN_PARALLELISM(1), .OUT_LARGE_COLUMNS(2)) dut_a (
        .clk(clk), .rst(rst), .data_in(din_a), .ind_table(ind_a),
        .data_in_valid(vin_a), .data_in_ready(rdy_a),
        .data_out_large(large_a), .data_out_small(small_a),
        .data_out_valid(vout_a), .data_out_ready(ordy_a), .err(err_a));

    scatter_stream #(.IN_WIDTH(16), .IN_SIZE(4), .IN_PARALLELISM(2), .OUT_LARGE_COLUMNS(1)) dut_b (
        .clk(clk), .rst(rst), .data_in(din_b), .ind_table(ind_b),
        .data_in_valid(vin_b), .data_in_ready(rdy_b),
        .data_out_large(large_b), .data_out_small(small_b),
        .data_out_valid(vout_b), .data_out_ready(ordy_b), .err(err_b));

    typedef struct {
        logic [3:0]  mask;
        logic [63:0] row;
        logic [31:0] exp_large;
        logic [31:0] exp_small;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [63:0] pack4(input logic [15:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    function automatic logic [31:0] pack2(input logic [15:0] s0, s1);
        return {s1, s0};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_a(input logic [3:0] m, input logic [63:0] row, output int lat);
        int n = 0;
        while (rdy_a !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        check("a_in_ready", rdy_a, 1);
        ind_a = m; din_a = row; vin_a = 1'b1;
        @(posedge clk); #1;
        vin_a = 1'b0;
        lat = 0;
        while (vout_a !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic release_a();
        check("a_ready_in_out", rdy_a, 0);
        ordy_a = 1'b1;
        @(posedge clk); #1;
        ordy_a = 1'b0;
        check("a_valid_drop", vout_a, 0);
        check("a_ready_back", rdy_a, 1);
        check("a_err_clear", err_a, 0);
    endtask

    task automatic run_b(input logic [3:0] m, input logic [127:0] rows,
                         input logic [31:0] exp_l, input logic [95:0] exp_s, input logic exp_e);
        int n = 0;
        int lat = 0;
        while (rdy_b !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        check("b_in_ready", rdy_b, 1);
        ind_b = m; din_b = rows; vin_b = 1'b1;
        @(posedge clk); #1;
        vin_b = 1'b0;
        while (vout_b !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        check("b_latency", lat, 4);
        check("b_large", large_b, exp_l);
        check("b_small", small_b, exp_s);
        check("b_err", err_b, ERR_ON & exp_e);
        ordy_b = 1'b1;
        @(posedge clk); #1;
        ordy_b = 1'b0;
        check("b_valid_drop", vout_b, 0);
        check("b_ready_back", rdy_b, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        vecs[0] = '{4'b0101, pack4(10, 20, 30, 40), pack2(10, 30), pack2(20, 40), 1'b0};
        vecs[1] = '{4'b0111, pack4(1, 2, 3, 4), pack2(1, 2), pack2(4, 0), 1'b1};
        vecs[2] = '{4'b0000, pack4(5, 6, 7, 8), pack2(0, 0), pack2(5, 6), 1'b1};
        vecs[3] = '{4'b1111, pack4(9, 10, 11, 12), pack2(9, 10), pack2(0, 0), 1'b1};
        vecs[4] = '{4'b1010, pack4(100, 200, 300, 400), pack2(200, 400), pack2(100, 300), 1'b0};
        vecs[5] = '{4'b1100, pack4(1, 2, 3, 4), pack2(3, 4), pack2(1, 2), 1'b0};
        vecs[6] = '{4'b0001, pack4(7, 8, 9, 10), pack2(7, 0), pack2(8, 9), 1'b1};
        vecs[7] = '{4'b0011, pack4(16'hFFFF, 16'h1234, 16'hABCD, 16'h0001),
                    pack2(16'hFFFF, 16'h1234), pack2(16'hABCD, 16'h0001), 1'b0};

        // Reset state
        #2;
        check("rst_ready", rdy_a, 0);
        check("rst_valid", vout_a, 0);
        check("rst_err", err_a, 0);
        check("rst_large", large_a, 0);
        check("rst_small", small_a, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", rdy_a, 1);

        // Table-driven routing
        for (int i = 0; i < 8; i++) begin
            send_a(vecs[i].mask, vecs[i].row, lat);
            check($sformatf("v%0d_latency", i), lat, 4);
            check($sformatf("v%0d_large", i), large_a, vecs[i].exp_large);
            check($sformatf("v%0d_small", i), small_a, vecs[i].exp_small);
            check($sformatf("v%0d_err", i), err_a, ERR_ON & vecs[i].exp_err);
            release_a();
        end

        // Backpressure: hold ready low for 10 cycles
        send_a(4'b1010, pack4(100, 200, 300, 400), lat);
        check("bp_latency", lat, 4);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("bp_valid", vout_a, 1);
            check("bp_large", large_a, pack2(200, 400));
            check("bp_small", small_a, pack2(100, 300));
            check("bp_ready", rdy_a, 0);
        end
        release_a();

        // Reset two cycles into SCAN
        ind_a = 4'b0011; din_a = pack4(1, 2, 3, 4); vin_a = 1'b1;
        @(posedge clk); #1;
        vin_a = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("mid_scan_large", large_a, pack2(1, 2));
        rst = 1'b1;
        #1;
        check("mid_rst_valid", vout_a, 0);
        check("mid_rst_large", large_a, 0);
        check("mid_rst_small", small_a, 0);
        check("mid_rst_ready", rdy_a, 0);
        @(negedge clk);
        rst = 1'b0;
        send_a(vecs[0].mask, vecs[0].row, lat);
        check("after_rst_latency", lat, 4);
        check("after_rst_large", large_a, vecs[0].exp_large);
        check("after_rst_small", small_a, vecs[0].exp_small);
        release_a();

        // Ignored stimulus during SCAN/OUT
        ind_a = 4'b0101; din_a = pack4(10, 20, 30, 40); vin_a = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (vout_a !== 1'b1 && lat < 20) begin
            ind_a = ~ind_a;
            din_a = {$urandom, $urandom};
            vin_a = ~vin_a;
            @(posedge clk); #1;
            lat++;
            check("ign_ready", rdy_a, 0);
        end
        check("ign_latency", lat, 4);
        check("ign_large", large_a, pack2(10, 30));
        check("ign_small", small_a, pack2(20, 40));
        check("ign_err", err_a, 0);
        vin_a = 1'b0;
        release_a();
        repeat (6) @(posedge clk);
        #1;
        check("ign_no_second_beat", vout_a, 0);
        check("ign_still_idle", rdy_a, 1);

        // Multi-row beats, L=1
        run_b(4'b1000, {pack4(5, 6, 7, 8), pack4(1, 2, 3, 4)},
              {16'd8, 16'd4}, {16'd7, 16'd6, 16'd5, 16'd3, 16'd2, 16'd1}, 1'b0);
        run_b(4'b0110, {pack4(5, 6, 7, 8), pack4(1, 2, 3, 4)},
              {16'd6, 16'd2}, {16'd0, 16'd8, 16'd5, 16'd0, 16'd4, 16'd1}, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
